// File: rtl/crc_read_controller_if.sv
// Handshake and status bundle between a read requester and the CRC read controller.
// Ports: read/syndrome_zero from the requester and checker; strobes, busy/valid and
// crc_error/err_cnt status back from the controller.
interface crc_read_controller_if;
    logic       read;
    logic       syndrome_zero;
    logic       read_mem_en;
    logic       load_en;
    logic       shift_en;
    logic       read_busy;
    logic       read_valid;
    logic       crc_error;
    logic [7:0] err_cnt;

    modport master (
        output read,
        output syndrome_zero,
        input  read_mem_en,
        input  load_en,
        input  shift_en,
        input  read_busy,
        input  read_valid,
        input  crc_error,
        input  err_cnt
    );

    modport slave (
        input  read,
        input  syndrome_zero,
        output read_mem_en,
        output load_en,
        output shift_en,
        output read_busy,
        output read_valid,
        output crc_error,
        output err_cnt
    );
endinterface

// File: rtl/crc_read_controller.sv
// Sequences one memory read through a serial CRC checker: fetch, load, shift
// DATA_W+CRC_W bits, check the syndrome, then report.
// Ports: clk, rst (sync, active high), bus (slave side of crc_read_controller_if):
//   read, syndrome_zero in; read_mem_en, load_en, shift_en, read_busy,
//   read_valid, crc_error, err_cnt out.
module crc_read_controller #(
    parameter int DATA_W = 32,
    parameter int CRC_W  = 8
) (
    input logic                 clk,
    input logic                 rst,
    crc_read_controller_if.slave bus
);
    localparam int N     = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pending;
    logic             pending_next;
    logic             crc_error_q;
    logic [7:0]       err_cnt_q;

    logic             mem_en;
    logic             ld_en;
    logic             sh_en;
    logic             busy;
    logic             valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
        end
    end

    // Result registers only move on the closing edge of CHECK, so the
    // last result stays visible until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_error_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else if (state == CHECK) begin
            crc_error_q <= ~bus.syndrome_zero;
            if (!bus.syndrome_zero && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        mem_en       = 1'b0;
        ld_en        = 1'b0;
        sh_en        = 1'b0;
        valid        = 1'b0;
        busy         = (state != IDLE);

        // One-deep queue: a request arriving mid-transaction is remembered;
        // a request while one is already remembered is dropped. DONE
        // consumes the request directly instead of queueing it.
        if (bus.read && state != IDLE && state != DONE) begin
            pending_next = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (bus.read) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_en     = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                ld_en      = 1'b1;
                cnt_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                sh_en = 1'b1;
                if (cnt == LAST) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CHECK: begin
                state_next = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (pending) begin
                    pending_next = 1'b0;
                    state_next   = FETCH;
                end else if (bus.read) begin
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.read_mem_en = mem_en;
    assign bus.load_en     = ld_en;
    assign bus.shift_en    = sh_en;
    assign bus.read_busy   = busy;
    assign bus.read_valid  = valid;
    assign bus.crc_error   = crc_error_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: doc/crc_read_controller.md
CRC_READ_CONTROLLER -- requirements
Module: crc_read_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bits shifted through the serial CRC checker.
REQ-002 SHALL have parameter CRC_W, default 8, meaning CRC bits shifted after data; shift length N = DATA_W + CRC_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port read, input, 1, read request, sampled each edge.
REQ-006 SHALL have port syndrome_zero, input, 1, checker remainder equals zero; valid only in CHECK.
REQ-007 SHALL have port read_mem_en, output, 1, one-cycle memory read strobe.
REQ-008 SHALL have port load_en, output, 1, loads fetched codeword into the checker shift register.
REQ-009 SHALL have port shift_en, output, 1, advances the checker by one bit.
REQ-010 SHALL have port read_busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port read_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port crc_error, output, 1, check result; held from DONE until the next DONE.
REQ-013 SHALL have port err_cnt, output, 8, saturating count of failed checks.

Function
REQ-014 SHALL implement states IDLE, FETCH, LOAD, SHIFT, CHECK, DONE, encoded one register, all outputs decoded from state (Moore), except crc_error and err_cnt, which are registers.
REQ-015 IDLE: read=1 at edge T -> FETCH after T; read=0 -> stay IDLE.
REQ-016 FETCH lasts exactly 1 cycle with read_mem_en=1, then LOAD.
REQ-017 LOAD lasts exactly 1 cycle with load_en=1, then SHIFT; shift counter cleared to 0 on LOAD.
REQ-018 SHIFT holds shift_en=1 for exactly N consecutive cycles; counter width ceil(log2(N+1)); leaves to CHECK when count reaches N-1 at an edge (no extra shift).
REQ-019 CHECK lasts 1 cycle; at its closing edge crc_error <= ~syndrome_zero, and if syndrome_zero=0 and err_cnt<255, err_cnt increments.
REQ-020 err_cnt SHALL saturate at 255; no wrap.
REQ-021 DONE lasts 1 cycle with read_valid=1; next state FETCH if pending=1 (pending cleared), else IDLE.
REQ-022 Latency: request accepted at edge T -> read_valid high in cycle after edge T+N+3.
REQ-023 read=1 sampled in any non-IDLE state SHALL set a 1-deep pending flag; further requests while pending=1 are dropped.
REQ-024 read=1 in DONE SHALL set pending and thus be served back-to-back (no IDLE cycle).
REQ-025 read_mem_en, load_en, shift_en, read_valid SHALL be mutually exclusive; at most one high per cycle.
REQ-026 syndrome_zero SHALL be ignored outside CHECK.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, clear shift counter, pending, crc_error and err_cnt to 0, and all strobes to 0 from the next cycle, in any state including mid-SHIFT.
REQ-028 rst SHALL take priority over read; a read sampled with rst=1 is not accepted and not pended.
REQ-029 After rst deasserts, a read SHALL be accepted on the first edge with rst=0.

Verification (DATA_W=32, CRC_W=8, N=40)
REQ-030 Single read, pulse read 1 cycle, syndrome_zero=1 -> read_mem_en 1 cycle, load_en 1 cycle, shift_en exactly 40 cycles, read_valid in cycle T+43, crc_error=0, err_cnt=0.
REQ-031 Single read with syndrome_zero=0 during CHECK -> crc_error=1 from DONE onward, err_cnt=1; next clean read -> crc_error=0, err_cnt stays 1.
REQ-032 read held high 2 cycles, then second pulse mid-SHIFT -> exactly two transactions back-to-back (DONE directly to FETCH), third request dropped; two read_valid pulses 44 cycles apart.
REQ-033 rst asserted 1 cycle at SHIFT count 20 -> IDLE next cycle, shift_en low, pending/err_cnt cleared, no read_valid; new read then completes normally.
REQ-034 260 consecutive failing reads -> err_cnt reads 255 and holds; bench asserts strobes one-hot or zero every cycle.
